sipo_deserializer: RTL and testbench
====================================

Name: sipo_deserializer

Overview:
- Serial-in/parallel-out front end for the parallel register stage.
- Collects a qualified serial bit stream into WIDTH-bit words and presents each completed word on a one-entry output holding register with a valid/ready handshake.
- Flags any word lost to downstream backpressure with a sticky overrun flag.
- Sits directly upstream of the parallel-load register; word_out drives its D input.

Parameters:
- WIDTH, 4, word width in bits; must be >= 2.
- MSB_FIRST, 1, 1 = first received bit lands in word_out[WIDTH-1]; 0 = first received bit lands in word_out[0].
- CNT_W, 3, width of bit_count; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock for all state.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- clear  input  1  synchronous clear, active-high.
- bit_in  input  1  serial data; sampled only when bit_valid=1.
- bit_valid  input  1  qualifies bit_in on this clk edge.
- word_out  output  WIDTH  assembled word; stable while word_valid=1.
- word_valid  output  1  holding register full.
- word_ready  input  1  downstream accepts word_out on this edge.
- bit_count  output  CNT_W  bits of the current partial word received, 0..WIDTH-1.
- overrun  output  1  sticky; a completed word was dropped.

Behaviour:
- Reset (async, reset=1): shift register, bit_count, word_out, word_valid and overrun all go to 0 immediately and stay 0 while reset is high.
- Clear (sync, clear=1 at edge): same result as reset. Overrides every other event on that edge; bit_valid and word_ready are ignored.
- Shift on each edge with bit_valid=1:
  - MSB_FIRST=1: sh <= {sh[WIDTH-2:0], bit_in}.
  - MSB_FIRST=0: sh <= {bit_in, sh[WIDTH-1:1]}.
  - bit_count increments. When bit_valid=0, shift register and bit_count hold; gaps of any length are allowed.
- Word completion: an edge with bit_valid=1 and bit_count==WIDTH-1.
  - bit_count wraps to 0.
  - The assembled word, including this bit, is the candidate word.
- Output stage FSM has 2 states: EMPTY (word_valid=0) and FULL (word_valid=1).
  - EMPTY, completion: word_out <= candidate; go to FULL. word_valid rises in the cycle after the edge that sampled the last bit (latency 1).
  - FULL, word_ready=1, no completion: go to EMPTY. word_out keeps its last value and is not zeroed.
  - FULL, word_ready=1, completion on the same edge: word_out <= candidate; stay FULL. word_valid stays high and no overrun is flagged.
  - FULL, word_ready=0, completion: candidate is dropped; word_out is unchanged; overrun <= 1. The shift path keeps running normally.
  - FULL, word_ready=0, no completion: hold.
- word_ready has no effect in EMPTY.
- overrun clears only on reset or clear.
- A partial word is discarded by reset or clear; the next bit starts a fresh word at bit_count=0.
- bit_in value is irrelevant when bit_valid=0, including X.

Test Plan (WIDTH=4, CNT_W=3 unless noted):
- Reset: assert reset mid-cycle with no clk edge -> word_out=0, word_valid=0, bit_count=0, overrun=0 immediately.
- MSB_FIRST=1, word_ready=1, bits 1,0,1,1 on consecutive edges -> bit_count steps 1,2,3,0; word_valid high for exactly 1 cycle, starting the cycle after the 4th bit; word_out=4'b1011; word_out holds 1011 afterwards.
- MSB_FIRST=0, same stimulus with 2 idle cycles (bit_valid=0, bit_in=X) between bits 2 and 3 -> word_out=4'b1101; bit_count holds at 2 during the idle cycles.
- Backpressure: word_ready=0, send 1011 then 0110 -> word_out stays 1011, overrun=1 after the 8th bit; raise word_ready -> word_valid drops after 1 edge; overrun stays 1 until clear is pulsed, then 0.
- Simultaneous: word_valid=1 (1011), word_ready=1 on the same edge the 4th bit of 0110 arrives -> word_out=0110, word_valid continuously high, overrun=0.
- Reset/clear mid-word: send bits 1,1, then pulse clear together with bit_valid=1 -> bit_count=0, no shift; then send 0,1,0,1 -> word_out=4'b0101. Repeat with async reset instead of clear -> same result.

Source files
------------

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: serial-to-parallel word assembler with a one-entry valid/ready output register and sticky overrun flag
module sipo_deserializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [CNT_W-1:0] bit_count,
    output logic             overrun
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t           state, next_state;
    logic [WIDTH-1:0] sh, cand;
    logic             complete, load, drop;
    // cand is the shift register as it will look after this edge's bit
    always_comb begin
        cand       = MSB_FIRST ? {sh[WIDTH-2:0], bit_in} : {bit_in, sh[WIDTH-1:1]};
        complete   = bit_valid && bit_count == CNT_W'(WIDTH - 1);
        load       = complete && (state == EMPTY || word_ready);
        drop       = complete && state == FULL && !word_ready;
        next_state = load ? FULL : (state == FULL && word_ready) ? EMPTY : state;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= EMPTY;
        else if (clear) state <= EMPTY;
        else state <= next_state;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            sh        <= '0;
            bit_count <= '0;
            word_out  <= '0;
            overrun   <= 1'b0;
        end else if (clear) begin
            sh        <= '0;
            bit_count <= '0;
            word_out  <= '0;
            overrun   <= 1'b0;
        end else begin
            if (bit_valid) begin
                sh        <= cand;
                bit_count <= complete ? '0 : bit_count + 1'b1;
            end
            if (load) word_out <= cand;
            if (drop) overrun <= 1'b1;
        end
    assign word_valid = state == FULL;
endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: directed and random stimulus for both bit orders, checked against a queue-based word model
module tb_sipo_deserializer;
    localparam int W = 4;
    logic clk = 1'b0, reset = 1'b0, clear = 1'b0, bit_in = 1'b0, bit_valid = 1'b0, word_ready = 1'b0;
    logic [W-1:0] wo_m, wo_l;
    logic wv_m, wv_l, ov_m, ov_l;
    logic [2:0] bc_m, bc_l;
    int tests = 0, fails = 0;
    bit q[$];
    logic [W-1:0] m_out_m, m_out_l;
    bit m_valid, m_ovr;

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1), .CNT_W(3)) dut_m (
        .clk(clk), .reset(reset), .clear(clear), .bit_in(bit_in), .bit_valid(bit_valid),
        .word_out(wo_m), .word_valid(wv_m), .word_ready(word_ready), .bit_count(bc_m), .overrun(ov_m));
    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0), .CNT_W(3)) dut_l (
        .clk(clk), .reset(reset), .clear(clear), .bit_in(bit_in), .bit_valid(bit_valid),
        .word_out(wo_l), .word_valid(wv_l), .word_ready(word_ready), .bit_count(bc_l), .overrun(ov_l));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("msb_word_out", 32'(wo_m), 32'(m_out_m));
        chk("msb_word_valid", 32'(wv_m), 32'(m_valid));
        chk("msb_bit_count", 32'(bc_m), q.size());
        chk("msb_overrun", 32'(ov_m), 32'(m_ovr));
        chk("lsb_word_out", 32'(wo_l), 32'(m_out_l));
        chk("lsb_word_valid", 32'(wv_l), 32'(m_valid));
        chk("lsb_bit_count", 32'(bc_l), q.size());
        chk("lsb_overrun", 32'(ov_l), 32'(m_ovr));
    endtask

    task automatic model_clear();
        q.delete();
        m_out_m = '0;
        m_out_l = '0;
        m_valid = 0;
        m_ovr   = 0;
    endtask

    // word completion builds both bit orders from the received bit list
    task automatic step(input bit clr, input bit bv, input logic bi, input bit rdy);
        logic [W-1:0] cm, cl;
        bit done;
        clear = clr; bit_valid = bv; bit_in = bv ? bi : 1'bx; word_ready = rdy;
        @(posedge clk);
        if (clr) model_clear();
        else begin
            done = bv && q.size() == W - 1;
            if (bv) q.push_back(bi);
            if (done) begin
                cm = '0; cl = '0;
                for (int i = 0; i < W; i++) begin
                    cm[W-1-i] = q[i];
                    cl[i]     = q[i];
                end
                q.delete();
                if (!m_valid || rdy) begin
                    m_out_m = cm; m_out_l = cl; m_valid = 1;
                end else m_ovr = 1;
            end else if (m_valid && rdy) m_valid = 0;
        end
        #1;
        clear = 1'b0;
        check_all();
    endtask

    task automatic send(input logic [W-1:0] bits, input bit rdy);
        for (int i = W - 1; i >= 0; i--) step(0, 1, bits[i], rdy);
    endtask

    task automatic async_reset();
        reset = 1'b1;
        #1;
        model_clear();
        check_all();
        #2;
        reset = 1'b0;
        #1;
        check_all();
    endtask

    initial begin
        model_clear();
        #2;
        reset = 1'b1;
        #1;
        check_all();
        #3;
        reset = 1'b0;
        check_all();
        // in-order word with ready held high
        send(4'b1011, 1);
        chk("dir_msb_word", 32'(wo_m), 32'hB);
        chk("dir_lsb_word", 32'(wo_l), 32'hD);
        step(0, 0, 0, 1);
        chk("dir_valid_drop", 32'(wv_m), 0);
        step(0, 0, 0, 1);
        chk("dir_word_hold", 32'(wo_m), 32'hB);
        // idle gap between bits 2 and 3
        step(0, 1, 1, 1); step(0, 1, 0, 1);
        step(0, 0, 1'bx, 1);
        chk("gap_count_hold", 32'(bc_l), 2);
        step(0, 0, 1'bx, 1);
        step(0, 1, 1, 1); step(0, 1, 1, 1);
        chk("gap_lsb_word", 32'(wo_l), 32'hD);
        step(0, 0, 0, 1);
        // backpressure drops the second word
        send(4'b1011, 0);
        send(4'b0110, 0);
        chk("bp_overrun", 32'(ov_m), 1);
        chk("bp_word_kept", 32'(wo_m), 32'hB);
        step(0, 0, 0, 1);
        chk("bp_valid_drop", 32'(wv_m), 0);
        chk("bp_overrun_sticky", 32'(ov_m), 1);
        step(1, 0, 0, 0);
        chk("bp_overrun_clr", 32'(ov_m), 0);
        // accept and complete on the same edge
        send(4'b1011, 0);
        step(0, 1, 0, 0); step(0, 1, 1, 0); step(0, 1, 1, 0);
        step(0, 1, 0, 1);
        chk("sim_word", 32'(wo_m), 32'h6);
        chk("sim_valid", 32'(wv_m), 1);
        chk("sim_no_overrun", 32'(ov_m), 0);
        step(0, 0, 0, 1);
        // clear mid-word, then async reset mid-word
        step(0, 1, 1, 1); step(0, 1, 1, 1);
        step(1, 1, 1, 1);
        chk("clr_count", 32'(bc_m), 0);
        send(4'b0101, 1);
        chk("clr_word", 32'(wo_m), 32'h5);
        step(0, 1, 1, 1); step(0, 1, 1, 1);
        async_reset();
        send(4'b0101, 1);
        chk("rst_word", 32'(wo_m), 32'h5);
        // random traffic
        for (int n = 0; n < 400; n++)
            step($urandom_range(0, 39) == 0, 1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
